// File: rtl/alu_lane_pkg.sv
// Shared types for the lane-split pipelined ALU: op encoding, mode layout and
// a small helper that tells which ops drive the carry/borrow flags.
package alu_lane_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_AND     = 3'd2,
    OP_OR      = 3'd3,
    OP_XOR     = 3'd4,
    OP_ACC     = 3'd5,
    OP_CLRACC  = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  localparam int MODE_LANE = 3;

  // Packed so that a raw 4-bit mode casts directly: {lane, op}.
  typedef struct packed {
    logic lane;
    op_e  op;
  } mode_t;

  function automatic logic op_has_carry(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ACC);
  endfunction

endpackage

// File: rtl/alu_lane.sv
// One LW-bit ALU lane. Purely combinational; cout is the raw adder carry-out
// (for SUB the borrow is its inverse), so it can be chained into the next lane.
module alu_lane
  import alu_lane_pkg::*;
#(
  parameter int LW = 4
) (
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  input  op_e           op,
  input  logic          cin,
  input  logic [LW-1:0] acc,
  output logic [LW-1:0] y,
  output logic          cout
);

  logic [LW:0] sum;

  always_comb begin
    sum  = '0;
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + (LW+1)'(cin);
        y    = sum[LW-1:0];
        cout = sum[LW];
      end
      OP_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b} + (LW+1)'(cin);
        y    = sum[LW-1:0];
        cout = sum[LW];
      end
      OP_ACC: begin
        sum  = {1'b0, acc} + {1'b0, a} + (LW+1)'(cin);
        y    = sum[LW-1:0];
        cout = sum[LW];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_lane_pipe.sv
// Two-stage valid/ready ALU with full-width or lane-wise (SIMD) arithmetic,
// a running accumulator and per-lane carry/borrow flags.
module alu_lane_pipe
  import alu_lane_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic [3:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [LANES-1:0] carry,
  output logic             zero,
  output logic             err
);

  localparam int LW = WIDTH / LANES;

  if (LANES < 1 || (WIDTH % LANES) != 0) begin : g_param_check
    $error("alu_lane_pipe: WIDTH must be a multiple of LANES");
  end

  typedef struct packed {
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    mode_t            mode;
  } s1_t;

  s1_t              s1_p1;
  logic             vld_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] result_p2;
  logic [LANES-1:0] carry_p2;
  logic             zero_p2;
  logic             err_p2;
  logic [WIDTH-1:0] acc_p2;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = !rst && s1_adv;

  // ---- Stage 1: capture operands ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (s1_adv)
      vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_p1.left  <= left;
      s1_p1.right <= right;
      s1_p1.mode  <= mode_t'(mode);
    end
  end

  // ---- Stage 2: lane compute, flags and accumulator ----
  op_e              op_p1;
  logic             lane_p1;
  logic             is_sub;
  logic [WIDTH-1:0] y;
  logic [LANES-1:0] co;
  logic [LANES-1:0] carry_d;

  assign op_p1   = s1_p1.mode.op;
  assign lane_p1 = s1_p1.mode.lane;
  assign is_sub  = (op_p1 == OP_SUB);

  // SUB is invert-plus-one, so every independent chain starts with cin = 1.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic cin_l;
    logic co_l;

    if (i == 0) begin : g_first
      assign cin_l = is_sub;
    end else begin : g_chain
      assign cin_l = lane_p1 ? is_sub : g_lane[i-1].co_l;
    end

    alu_lane #(.LW(LW)) u_lane (
      .a    (s1_p1.left[i*LW +: LW]),
      .b    (s1_p1.right[i*LW +: LW]),
      .op   (op_p1),
      .cin  (cin_l),
      .acc  (acc_p2[i*LW +: LW]),
      .y    (y[i*LW +: LW]),
      .cout (co_l)
    );

    assign co[i] = co_l;
  end

  always_comb begin
    carry_d = '0;
    if (op_has_carry(op_p1)) begin
      if (lane_p1) begin
        for (int k = 0; k < LANES; k++)
          carry_d[k] = co[k] ^ is_sub;
      end else begin
        carry_d[LANES-1] = co[LANES-1] ^ is_sub;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      carry_p2  <= '0;
      zero_p2   <= 1'b0;
      err_p2    <= 1'b0;
      acc_p2    <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= y;
        carry_p2  <= carry_d;
        zero_p2   <= (y == '0);
        err_p2    <= (op_p1 == OP_ILLEGAL);
        // CLRACC lanes produce zero, so y is the new accumulator for both ops.
        if (op_p1 == OP_ACC || op_p1 == OP_CLRACC)
          acc_p2 <= y;
      end
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign carry     = carry_p2;
  assign zero      = zero_p2;
  assign err       = err_p2;

endmodule

// File: tb/tb_alu_lane_pipe.sv
// Bench for alu_lane_pipe (WIDTH=8, LANES=2): directed vector table, streaming
// corner sequences, async reset mid-flight and a randomized run against a model.
module tb_alu_lane_pipe;

  localparam int W  = 8;
  localparam int L  = 2;
  localparam int LW = W / L;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic [3:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [L-1:0] carry;
  logic         zero;
  logic         err;

  always #5 clk = ~clk;

  alu_lane_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .left      (left),
    .right     (right),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [3:0]   m;
    logic [W-1:0] res;
    logic [L-1:0] cy;
    logic         z;
    logic         e;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic [L-1:0] cy;
    logic         z;
    logic         e;
  } exp_t;

  // Reference model: plain integer arithmetic per lane or over the whole word.
  logic [W-1:0] m_acc;

  function automatic exp_t ref_model(input logic [W-1:0] l, input logic [W-1:0] r,
                                     input logic [3:0] m);
    exp_t x;
    int   op;
    int   a;
    int   b;
    int   s;
    op = int'(m[2:0]);
    x  = '0;
    if (op == 7) begin
      x.e = 1'b1;
    end else if (op == 2) begin
      x.res = l & r;
    end else if (op == 3) begin
      x.res = l | r;
    end else if (op == 4) begin
      x.res = l ^ r;
    end else if (op == 6) begin
      m_acc = '0;
    end else if (!m[3]) begin
      a = (op == 5) ? int'(m_acc) : int'(l);
      b = (op == 5) ? int'(l) : int'(r);
      s = (op == 1) ? a - b : a + b;
      x.res      = s[W-1:0];
      x.cy[L-1]  = (op == 1) ? (a < b) : (s >= (1 << W));
      if (op == 5) m_acc = x.res;
    end else begin
      for (int i = 0; i < L; i++) begin
        a = (op == 5) ? int'(m_acc[i*LW +: LW]) : int'(l[i*LW +: LW]);
        b = (op == 5) ? int'(l[i*LW +: LW]) : int'(r[i*LW +: LW]);
        s = (op == 1) ? a - b : a + b;
        x.res[i*LW +: LW] = s[LW-1:0];
        x.cy[i]           = (op == 1) ? (a < b) : (s >= (1 << LW));
      end
      if (op == 5) m_acc = x.res;
    end
    x.z = (x.res == '0);
    return x;
  endfunction

  // Single isolated transaction: checks 2-cycle latency and all outputs.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    left = v.l; right = v.r; mode = v.m; in_valid = 1'b1; out_ready = 1'b1;
    check({v.name, "/in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({v.name, "/early_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({v.name, "/out_valid"}, 32'(out_valid), 32'd1);
    check({v.name, "/result"}, 32'(result), 32'(v.res));
    check({v.name, "/carry"}, 32'(carry), 32'(v.cy));
    check({v.name, "/zero"}, 32'(zero), 32'(v.z));
    check({v.name, "/err"}, 32'(err), 32'(v.e));
  endtask

  // Streamed sequence: source offers every cycle, sink stalls for 'stall' cycles.
  logic [W-1:0] s_l [8];
  logic [W-1:0] s_r [8];
  logic [3:0]   s_m [8];
  logic [W-1:0] s_er[8];
  logic [L-1:0] s_ec[8];

  task automatic run_stream(input string name, input int n, input int stall);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < n && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      if (sent < n) begin
        in_valid = 1'b1; left = s_l[sent]; right = s_r[sent]; mode = s_m[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check($sformatf("%s/result%0d", name, got), 32'(result), 32'(s_er[got]));
        check($sformatf("%s/carry%0d", name, got), 32'(carry), 32'(s_ec[got]));
        if (out_ready) got++;
      end
      if (stall == 0 && sent < n)
        check($sformatf("%s/ready%0d", name, cyc), 32'(in_ready), 32'd1);
      if (stall > 0 && cyc >= 2 && cyc < stall) begin
        check($sformatf("%s/held_ready%0d", name, cyc), 32'(in_ready), 32'd0);
        check($sformatf("%s/held_count%0d", name, cyc), 32'(sent), 32'd2);
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check({name, "/completed"}, 32'(got), 32'(n));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  vec_t vt[11];
  exp_t q[$];
  exp_t ex;
  vec_t v;
  bit   first;

  initial begin
    vt[0]  = '{"add_full",  8'hF0, 8'h20, 4'b0000, 8'h10, 2'b10, 1'b0, 1'b0};
    vt[1]  = '{"sub_lane",  8'h35, 8'h17, 4'b1001, 8'h2E, 2'b01, 1'b0, 1'b0};
    vt[2]  = '{"sub_full",  8'h35, 8'h17, 4'b0001, 8'h1E, 2'b00, 1'b0, 1'b0};
    vt[3]  = '{"clracc",    8'h12, 8'h34, 4'b0110, 8'h00, 2'b00, 1'b1, 1'b0};
    vt[4]  = '{"acc80",     8'h80, 8'h00, 4'b0101, 8'h80, 2'b00, 1'b0, 1'b0};
    vt[5]  = '{"acc90",     8'h90, 8'h00, 4'b0101, 8'h10, 2'b10, 1'b0, 1'b0};
    vt[6]  = '{"illegal",   8'h33, 8'h44, 4'b0111, 8'h00, 2'b00, 1'b1, 1'b1};
    vt[7]  = '{"xor_zero",  8'h5A, 8'h5A, 4'b0100, 8'h00, 2'b00, 1'b1, 1'b0};
    vt[8]  = '{"add_lane",  8'h9F, 8'h98, 4'b1000, 8'h27, 2'b11, 1'b0, 1'b0};
    vt[9]  = '{"and_lane",  8'hC3, 8'h0F, 4'b1010, 8'h03, 2'b00, 1'b0, 1'b0};
    vt[10] = '{"or_full",   8'h50, 8'h0A, 4'b0011, 8'h5A, 2'b00, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    left = '0; right = '0; mode = '0;
    repeat (3) @(negedge clk);
    check("rst/in_ready", 32'(in_ready), 32'd0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/result", 32'(result), 32'd0);
    check("rst/flags", 32'({carry, zero, err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst/in_ready_after", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) apply_vec(vt[i]);

    // Accumulator ops issued back-to-back.
    s_l[0] = 8'h00; s_r[0] = 8'h00; s_m[0] = 4'b0110; s_er[0] = 8'h00; s_ec[0] = 2'b00;
    s_l[1] = 8'h80; s_r[1] = 8'h00; s_m[1] = 4'b0101; s_er[1] = 8'h80; s_ec[1] = 2'b00;
    s_l[2] = 8'h90; s_r[2] = 8'h00; s_m[2] = 4'b0101; s_er[2] = 8'h10; s_ec[2] = 2'b10;
    run_stream("acc_b2b", 3, 0);

    // Four ADDs against a 5-cycle sink stall.
    for (int i = 0; i < 4; i++) begin
      s_l[i] = 8'(i + 1); s_r[i] = 8'(i + 1); s_m[i] = 4'b0000;
      s_er[i] = 8'(2 * (i + 1)); s_ec[i] = 2'b00;
    end
    run_stream("backpressure", 4, 5);

    // Async reset with two ACCs in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; left = 8'h11; right = 8'h00; mode = 4'b0101;
    @(negedge clk);
    left = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst/pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/result", 32'(result), 32'd0);
    check("midrst/in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst/in_ready_after", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("midrst/no_stale", 32'(out_valid), 32'd0);
    end
    v = '{"midrst_add", 8'h01, 8'h01, 4'b0000, 8'h02, 2'b00, 1'b0, 1'b0};
    apply_vec(v);
    v = '{"midrst_acc", 8'h05, 8'h00, 4'b0101, 8'h05, 2'b00, 1'b0, 1'b0};
    apply_vec(v);

    // Randomized traffic with random stalls, checked against the model.
    m_acc = '0;
    first = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      left      = 8'($urandom);
      right     = 8'($urandom);
      mode      = first ? 4'b0110 : 4'($urandom_range(0, 15));
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("rnd/spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("rnd/outputs", 32'({result, carry, zero, err}), 32'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        ex = ref_model(left, right, mode);
        q.push_back(ex);
        first = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
      #1;
      if (out_valid) begin
        check("drain/outputs", 32'({result, carry, zero, err}), 32'(q[0]));
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    check("drain/empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
